// File: rtl/parking_occupancy_ctrl.sv
// parking_occupancy_ctrl: tracks parking lot occupancy from the car_enter and
// car_exit pulses against a fixed capacity. It drives the entry permit lamp,
// the full/empty/near-full status flags and two sticky error flags.
// Optional feature macro: PARKING_BCD_EN. When defined, a sequential
// double-dabble converter presents occupancy as two BCD digits. When it is
// undefined, the BCD outputs are tied to zero.
module parking_occupancy_ctrl #(
  parameter int unsigned CAPACITY  = 15,
  parameter int unsigned NEAR_FULL = 13,
  localparam int unsigned CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_enter,
  input  logic             car_exit,
  input  logic             err_clr,
  output logic [CNT_W-1:0] occupancy,
  output logic [CNT_W-1:0] free_spaces,
  output logic             full,
  output logic             empty,
  output logic             near_full,
  output logic             entry_allow,
  output logic             overflow_err,
  output logic             underflow_err,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             bcd_valid
);

  localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_AVAIL = 2'd1,
    ST_FULL  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t           r_state;
  logic             w_inc;
  logic             w_dec;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic             w_err_evt;
  logic [CNT_W-1:0] w_occ_nxt;
  state_t           w_cnt_state;

  // Decode this cycle's events and the saturated next occupancy.
  always_comb begin
    w_inc     = car_enter & ~car_exit;
    w_dec     = car_exit & ~car_enter;
    w_ovf_evt = w_inc & (occupancy == CAP_V);
    w_unf_evt = w_dec & (occupancy == '0);
    w_err_evt = w_ovf_evt | w_unf_evt;
    w_occ_nxt = occupancy;
    if (w_inc && !w_ovf_evt) begin
      w_occ_nxt = occupancy + CNT_W'(1);
    end else if (w_dec && !w_unf_evt) begin
      w_occ_nxt = occupancy - CNT_W'(1);
    end
  end

  // State that matches the next occupancy, used when the FSM leaves ERROR.
  always_comb begin
    w_cnt_state = ST_AVAIL;
    if (w_occ_nxt == '0) begin
      w_cnt_state = ST_EMPTY;
    end else if (w_occ_nxt == CAP_V) begin
      w_cnt_state = ST_FULL;
    end
  end

  // Register the occupancy, the derived flags, the sticky errors and the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_EMPTY;
      occupancy     <= '0;
      free_spaces   <= CAP_V;
      full          <= 1'b0;
      empty         <= 1'b1;
      near_full     <= (NEAR_FULL == 0);
      entry_allow   <= 1'b1;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      occupancy     <= w_occ_nxt;
      free_spaces   <= CAP_V - w_occ_nxt;
      full          <= (w_occ_nxt == CAP_V);
      empty         <= (w_occ_nxt == '0);
      near_full     <= (32'(w_occ_nxt) >= NEAR_FULL);
      overflow_err  <= w_ovf_evt | (overflow_err & ~err_clr);
      underflow_err <= w_unf_evt | (underflow_err & ~err_clr);

      if (w_err_evt) begin
        r_state     <= ST_ERROR;
        entry_allow <= 1'b0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_occ_nxt == CAP_V) begin
              r_state     <= ST_FULL;
              entry_allow <= 1'b0;
            end else if (w_occ_nxt != '0) begin
              r_state     <= ST_AVAIL;
              entry_allow <= 1'b1;
            end
          end
          ST_AVAIL: begin
            if (w_occ_nxt == '0) begin
              r_state     <= ST_EMPTY;
              entry_allow <= 1'b1;
            end else if (w_occ_nxt == CAP_V) begin
              r_state     <= ST_FULL;
              entry_allow <= 1'b0;
            end
          end
          ST_FULL: begin
            if (w_occ_nxt != CAP_V) begin
              r_state     <= (w_occ_nxt == '0) ? ST_EMPTY : ST_AVAIL;
              entry_allow <= 1'b1;
            end
          end
          ST_ERROR: begin
            if (err_clr) begin
              r_state     <= w_cnt_state;
              entry_allow <= (w_cnt_state != ST_FULL);
            end
          end
          default: begin
            r_state     <= w_cnt_state;
            entry_allow <= (w_cnt_state != ST_FULL);
          end
        endcase
      end
    end
  end

`ifdef PARKING_BCD_EN
  localparam int unsigned STEP_W = $clog2(CNT_W + 1);

  logic [CNT_W-1:0]  r_bin;
  logic [7:0]        r_work;
  logic [STEP_W-1:0] r_steps;
  logic              r_busy;
  logic              w_occ_chg;
  logic [3:0]        w_ones_adj;
  logic [3:0]        w_tens_adj;
  logic [7:0]        w_work_nxt;

  assign w_occ_chg = (w_occ_nxt != occupancy);

  // One double-dabble step: add 3 to each digit that is 5 or more, then shift in the next bit.
  always_comb begin
    w_ones_adj = (r_work[3:0] >= 4'd5) ? (r_work[3:0] + 4'd3) : r_work[3:0];
    w_tens_adj = (r_work[7:4] >= 4'd5) ? (r_work[7:4] + 4'd3) : r_work[7:4];
    w_work_nxt = 8'({w_tens_adj, w_ones_adj, r_bin[CNT_W-1]});
  end

  // Converter sequencer. An occupancy change aborts any conversion in flight and starts again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin     <= '0;
      r_work    <= '0;
      r_steps   <= '0;
      r_busy    <= 1'b0;
      bcd_tens  <= 4'd0;
      bcd_ones  <= 4'd0;
      bcd_valid <= 1'b1;
    end else if (w_occ_chg) begin
      r_bin     <= w_occ_nxt;
      r_work    <= '0;
      r_steps   <= STEP_W'(CNT_W);
      r_busy    <= 1'b1;
      bcd_valid <= 1'b0;
    end else if (r_busy) begin
      r_bin   <= r_bin << 1;
      r_work  <= w_work_nxt;
      r_steps <= r_steps - STEP_W'(1);
      if (r_steps == STEP_W'(1)) begin
        r_busy    <= 1'b0;
        bcd_tens  <= w_work_nxt[7:4];
        bcd_ones  <= w_work_nxt[3:0];
        bcd_valid <= 1'b1;
      end
    end
  end
`else
  assign bcd_tens  = 4'd0;
  assign bcd_ones  = 4'd0;
  assign bcd_valid = 1'b0;
`endif

endmodule

// File: doc/parking_occupancy_ctrl.md
Name: parking_occupancy_ctrl

Overview:
Consumes the single-cycle car_enter / car_exit pulses from the entry/exit sensor detector FSM and tracks lot occupancy against a fixed capacity. Drives the entry-gate permit lamp and full/empty/near-full status. Latches sticky overflow/underflow errors. Sits directly downstream of the detector, upstream of gate/display logic.

Parameters:
CAPACITY, 15, number of spaces; legal 1..99
NEAR_FULL, 13, occupancy at or above which near_full asserts; legal 0..CAPACITY
CNT_W, $clog2(CAPACITY+1), occupancy counter width; derived, not overridden

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high; clock clk
car_enter  in  1  one-cycle pulse: a car completed entry
car_exit  in  1  one-cycle pulse: a car completed exit
err_clr  in  1  synchronous clear of sticky errors and the ERROR state
occupancy  out  CNT_W  cars currently inside
free_spaces  out  CNT_W  CAPACITY - occupancy
full  out  1  occupancy == CAPACITY
empty  out  1  occupancy == 0
near_full  out  1  occupancy >= NEAR_FULL
entry_allow  out  1  gate permit lamp; high in EMPTY or AVAIL state only
overflow_err  out  1  sticky: entry seen while full
underflow_err  out  1  sticky: exit seen while empty
bcd_tens  out  4  BCD tens digit of occupancy (optional feature)
bcd_ones  out  4  BCD ones digit of occupancy (optional feature)
bcd_valid  out  1  BCD digits match current occupancy (optional feature)

Behaviour:
- All outputs registered. Reset: occupancy=0, free_spaces=CAPACITY, empty=1, full=0, near_full=(NEAR_FULL==0), entry_allow=1, both errors 0, state EMPTY, bcd_* = 0, bcd_valid=1.
- Latency: pulse sampled at edge N; occupancy and every flag updated at edge N; visible after edge N.
- Event decode per cycle (e=car_enter, x=car_exit):
  - e&~x: increment if occupancy<CAPACITY. Else hold and set overflow_err.
  - x&~e: decrement if occupancy>0. Else hold and set underflow_err.
  - e&x: net zero, occupancy holds, no error, even at 0 or CAPACITY.
  - neither: hold.
- Occupancy never wraps. It saturates at 0 and CAPACITY.
- free_spaces, full, empty, near_full are derived from the next occupancy value and registered alongside it, so they never lag occupancy.
- State machine EMPTY / AVAIL / FULL / ERROR, evaluated each cycle on the next occupancy:
  - EMPTY -> AVAIL when occupancy becomes >0.
  - AVAIL -> EMPTY at 0.
  - AVAIL -> FULL at CAPACITY.
  - FULL -> AVAIL below CAPACITY.
  - Any state -> ERROR on an overflow or underflow event. Error event has priority over the count-based transition.
  - ERROR holds until err_clr. Occupancy keeps tracking legal events while in ERROR.
  - err_clr: clears both errors and leaves ERROR for the state matching occupancy, same cycle. If err_clr coincides with a new error event, the error wins: flag set, stays in ERROR.
  - CAPACITY==1: EMPTY<->FULL directly.
- entry_allow=0 in FULL and ERROR.
- Reset mid-operation: occupancy is lost and returns to reset values. No recovery.

Optional Feature:
PARKING_BCD_EN
- Defined: sequential shift-add-3 (double-dabble) converter.
  - Starts the cycle after occupancy changes; bcd_valid drops to 0 that same cycle.
  - Runs CNT_W cycles, then loads bcd_tens/bcd_ones and raises bcd_valid.
  - An occupancy change during conversion aborts and restarts it from the new value.
- Not defined: bcd_tens=bcd_ones=0 and bcd_valid=0 constantly. No converter logic.

Test Plan:
1. Reset, then 3 car_enter pulses -> occupancy=3, free_spaces=12, empty=0, entry_allow=1; each step visible one edge after its pulse.
2. 15 entries -> full=1, near_full=1 from occupancy 13, entry_allow=0, state FULL. 16th entry -> occupancy stays 15, overflow_err=1, state ERROR. One exit -> occupancy 14, still ERROR. err_clr -> AVAIL, entry_allow=1.
3. From reset, car_exit -> occupancy 0, underflow_err=1. err_clr -> EMPTY, errors 0.
4. Simultaneous car_enter&car_exit at occupancy 0, at 7 and at 15 -> occupancy unchanged, no error flags.
5. err_clr in the same cycle as an overflow entry -> overflow_err stays 1, state ERROR.
6. PARKING_BCD_EN defined: enter to occupancy 12 -> bcd_valid low, then after CNT_W=4 cycles bcd_tens=1, bcd_ones=2, bcd_valid=1. Second entry mid-conversion -> result 1/3, valid 4 cycles after the restart.
